// File: rtl/exec_control.sv
// Instruction sequencer: fetch/decode/execute FSM that owns pc, IR', the
// CARRY/SKIP flags and the retired-instruction counter.
module exec_control #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] memdata,
  input  logic        memvalid,
  output logic        fetchreq,
  output logic [15:0] pc,
  output logic [15:0] instruction,
  output logic        exec1,
  input  logic        carryout,
  input  logic        skipout,
  input  logic        carryen,
  input  logic        skipen,
  input  logic        wenout,
  output logic        carrystatus,
  output logic        skipstatus,
  output logic        regwen,
  output logic [15:0] instret
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC1  = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_fetchreq;
  logic        r_exec1;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_instret;
  logic        r_carry;
  logic        r_skip;

  // fetchreq/exec1 are registered alongside the state so they never glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FETCH;
      r_fetchreq <= 1'b1;
      r_exec1    <= 1'b0;
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_instret  <= '0;
      r_carry    <= 1'b0;
      r_skip     <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (memvalid) begin
            r_ir       <= memdata;
            r_fetchreq <= 1'b0;
            r_state    <= DECODE;
          end
        end
        DECODE: begin
          if (r_skip) begin
            r_skip     <= 1'b0;
            r_pc       <= r_pc + 16'd1;
            r_fetchreq <= 1'b1;
            r_state    <= FETCH;
          end else begin
            r_exec1    <= 1'b1;
            r_state    <= EXEC1;
          end
        end
        EXEC1: begin
          if (carryen) r_carry <= carryout;
          if (skipen)  r_skip  <= skipout;
          r_pc       <= r_pc + 16'd1;
          r_instret  <= r_instret + 16'd1;
          r_exec1    <= 1'b0;
          r_fetchreq <= 1'b1;
          r_state    <= FETCH;
        end
        default: begin
          r_exec1    <= 1'b0;
          r_fetchreq <= 1'b1;
          r_state    <= FETCH;
        end
      endcase
    end
  end

  assign fetchreq    = r_fetchreq;
  assign exec1       = r_exec1;
  assign pc          = r_pc;
  assign instruction = r_ir;
  assign instret     = r_instret;
  assign carrystatus = r_carry;
  assign skipstatus  = r_skip;
  // Reset masks the write strobe immediately, before the state is cleared.
  assign regwen      = wenout & r_exec1 & ~reset;

endmodule

// File: tb/tb_exec_control.sv
// Directed bench for exec_control: instruction sequencing, wait states,
// flag updates, skip, pc wrap and reset during execute.
module tb_exec_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] memdata;
  logic        memvalid;
  logic        fetchreq;
  logic [15:0] pc;
  logic [15:0] instruction;
  logic        exec1;
  logic        carryout, skipout, carryen, skipen, wenout;
  logic        carrystatus, skipstatus, regwen;
  logic [15:0] instret;

  always #5 clk = ~clk;

  exec_control #(.RESET_PC(16'hFFFE)) dut (
    .clk(clk), .reset(reset), .memdata(memdata), .memvalid(memvalid),
    .fetchreq(fetchreq), .pc(pc), .instruction(instruction), .exec1(exec1),
    .carryout(carryout), .skipout(skipout), .carryen(carryen),
    .skipen(skipen), .wenout(wenout), .carrystatus(carrystatus),
    .skipstatus(skipstatus), .regwen(regwen), .instret(instret)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_pc, exp_ir, exp_instret;
  logic        exp_carry, exp_skip;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive flag enables toward wrong values; outside EXEC1 they must be ignored.
  task automatic distract();
    carryen  = 1'b1;
    carryout = ~exp_carry;
    skipen   = 1'b1;
    skipout  = ~exp_skip;
    wenout   = 1'b1;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_carry"},   carrystatus, exp_carry);
    check({tag, "_skip"},    skipstatus,  exp_skip);
    check({tag, "_instret"}, instret,     exp_instret);
  endtask

  task automatic run_instr(input logic [15:0] data, input int waits,
                           input logic cen, input logic cout,
                           input logic sen, input logic sout, input logic wen);
    check("fetch_req",   fetchreq, 1'b1);
    check("fetch_exec1", exec1,    1'b0);
    check("fetch_pc",    pc,       exp_pc);
    for (int i = 0; i < waits; i++) begin
      memvalid = 1'b0;
      memdata  = 16'hDEAD;
      distract();
      step();
      check("wait_req",   fetchreq,    1'b1);
      check("wait_pc",    pc,          exp_pc);
      check("wait_ir",    instruction, exp_ir);
      check("wait_exec1", exec1,       1'b0);
    end
    memvalid = 1'b1;
    memdata  = data;
    distract();
    step();
    exp_ir = data;
    check("dec_ir",     instruction, exp_ir);
    check("dec_req",    fetchreq,    1'b0);
    check("dec_exec1",  exec1,       1'b0);
    check("dec_regwen", regwen,      1'b0);
    check_flags("dec");
    memvalid = 1'b1;
    memdata  = ~data;
    distract();
    if (exp_skip) begin
      step();
      exp_skip = 1'b0;
      exp_pc   = exp_pc + 16'd1;
      check("skip_exec1", exec1,    1'b0);
      check("skip_req",   fetchreq, 1'b1);
      check("skip_pc",    pc,       exp_pc);
      check("skip_ir",    instruction, exp_ir);
      check_flags("skip");
    end else begin
      step();
      check("ex_exec1", exec1,       1'b1);
      check("ex_pc",    pc,          exp_pc);
      check("ex_ir",    instruction, exp_ir);
      check("ex_req",   fetchreq,    1'b0);
      carryen  = cen;
      carryout = cout;
      skipen   = sen;
      skipout  = sout;
      wenout   = wen;
      #1;
      check("ex_regwen", regwen, wen);
      step();
      exp_pc      = exp_pc + 16'd1;
      exp_instret = exp_instret + 16'd1;
      if (cen) exp_carry = cout;
      if (sen) exp_skip  = sout;
      check("post_pc",    pc,          exp_pc);
      check("post_exec1", exec1,       1'b0);
      check("post_ir",    instruction, exp_ir);
      check_flags("post");
    end
    memvalid = 1'b0;
    distract();
  endtask

  initial begin
    reset    = 1'b1;
    memvalid = 1'b0;
    memdata  = '0;
    carryen  = 1'b0;
    carryout = 1'b0;
    skipen   = 1'b0;
    skipout  = 1'b0;
    wenout   = 1'b0;
    step();
    step();
    exp_pc      = 16'hFFFE;
    exp_ir      = '0;
    exp_instret = '0;
    exp_carry   = 1'b0;
    exp_skip    = 1'b0;
    check("rst_pc",    pc,          exp_pc);
    check("rst_ir",    instruction, 16'h0000);
    check("rst_exec1", exec1,       1'b0);
    check("rst_req",   fetchreq,    1'b1);
    check_flags("rst");
    reset = 1'b0;

    run_instr(16'hC000, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); // pc FFFE->FFFF, carry set
    run_instr(16'hC000, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // wait states, wrap to 0000, carry held
    run_instr(16'h0123, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1); // non-ARM, clears carry, sets skip
    run_instr(16'hC000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // skipped
    run_instr(16'hC001, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); // executes normally
    for (int k = 0; k < 3; k++)
      run_instr(16'hC000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("seq_pc",      pc,      16'h0006);
    check("seq_instret", instret, 16'h0007);

    // Reset asserted while in EXEC1 with all enables high.
    memvalid = 1'b1;
    memdata  = 16'hC0DE;
    step();
    memvalid = 1'b0;
    step();
    check("rx_exec1", exec1, 1'b1);
    carryen  = 1'b1;
    carryout = 1'b1;
    skipen   = 1'b1;
    skipout  = 1'b1;
    wenout   = 1'b1;
    reset    = 1'b1;
    #1;
    check("rx_regwen", regwen, 1'b0);
    step();
    check("rx_pc",      pc,          16'hFFFE);
    check("rx_carry",   carrystatus, 1'b0);
    check("rx_skip",    skipstatus,  1'b0);
    check("rx_instret", instret,     16'h0000);
    check("rx_ir",      instruction, 16'h0000);
    check("rx_exec1b",  exec1,       1'b0);
    check("rx_req",     fetchreq,    1'b1);
    reset = 1'b0;
    step();
    check("rel_req",   fetchreq, 1'b1);
    check("rel_exec1", exec1,    1'b0);
    check("rel_pc",    pc,       16'hFFFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
